// File: rtl/bcd_counter_0_99.sv
// Two-digit BCD up/down counter (00..99) with saturation, optional clear-on-99
// and an automatic reload to 25 when the count drops below 05.
module bcd_counter_0_99 (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic auto_repor,
  input  logic reset_no_99,
  output logic M3,
  output logic M2,
  output logic M1,
  output logic M0,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0
);

  localparam logic [3:0] DigitMax  = 4'd9;
  localparam logic [3:0] DigitZero = 4'd0;
  localparam logic [3:0] ReloadT   = 4'd2;
  localparam logic [3:0] ReloadU   = 4'd5;

  // Decade slice, counting up: returns {carry, next_digit}; codes 10..15 go to 0.
  function automatic logic [4:0] digit_up(input logic [3:0] d);
    logic [4:0] r;
    if (d > DigitMax) begin
      r = {1'b0, DigitZero};
    end else if (d == DigitMax) begin
      r = {1'b1, DigitZero};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

  // Decade slice, counting down: returns {borrow, next_digit}; codes 10..15 go to 0.
  function automatic logic [4:0] digit_down(input logic [3:0] d);
    logic [4:0] r;
    if (d > DigitMax) begin
      r = {1'b0, DigitZero};
    end else if (d == DigitZero) begin
      r = {1'b1, DigitMax};
    end else begin
      r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  logic [3:0] u_q, u_d;
  logic [3:0] t_q, t_d;

  logic u9, t9, c99;
  logic t0, u0, u_lt5, below5, zero;

  always_comb begin
    u9     = (u_q == DigitMax);
    t9     = (t_q == DigitMax);
    c99    = u9 & t9;
    t0     = (t_q == DigitZero);
    u0     = (u_q == DigitZero);
    u_lt5  = (u_q < 4'd5);
    below5 = t0 & u_lt5;
    zero   = t0 & u0;
  end

  logic [4:0] u_up, t_up, u_dn, t_dn;

  always_comb begin
    u_up = digit_up(u_q);
    t_up = digit_up(t_q);
    u_dn = digit_down(u_q);
    t_dn = digit_down(t_q);
  end

  // Priority chain; the tens digit moves on the same edge as the units wrap.
  always_comb begin
    u_d = u_q;
    t_d = t_q;
    if (reset_no_99 && c99) begin
      u_d = DigitZero;
      t_d = DigitZero;
    end else if (auto_repor && below5) begin
      u_d = ReloadU;
      t_d = ReloadT;
    end else if (inc) begin
      if (!c99) begin
        u_d = u_up[3:0];
        if (u_up[4]) begin
          t_d = t_up[3:0];
        end
      end
    end else begin
      if (!zero) begin
        u_d = u_dn[3:0];
        if (u_dn[4]) begin
          t_d = t_dn[3:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      u_q <= DigitZero;
      t_q <= DigitZero;
    end else begin
      u_q <= u_d;
      t_q <= t_d;
    end
  end

  assign {M3, M2, M1, M0} = u_q;
  assign {S3, S2, S1, S0} = t_q;

endmodule

// File: tb/tb_bcd_counter_0_99.sv
// Self-checking bench for bcd_counter_0_99: directed scenarios plus randomized
// stimulus against an integer-count reference model.
module tb_bcd_counter_0_99;

  logic clock = 1'b0;
  logic reset;
  logic inc, auto_repor, reset_no_99;
  logic M3, M2, M1, M0, S3, S2, S1, S0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          model_cnt = 0;

  always #5 clock = ~clock;

  bcd_counter_0_99 dut (
    .clock      (clock),
    .reset      (reset),
    .inc        (inc),
    .auto_repor (auto_repor),
    .reset_no_99(reset_no_99),
    .M3         (M3),
    .M2         (M2),
    .M1         (M1),
    .M0         (M0),
    .S3         (S3),
    .S2         (S2),
    .S1         (S1),
    .S0         (S0)
  );

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got T=%h U=%h, expected T=%h U=%h", tag, obs[7:4], obs[3:0],
               exp[7:4], exp[3:0]);
    end
  endtask

  function automatic logic [7:0] dout();
    return {S3, S2, S1, S0, M3, M2, M1, M0};
  endfunction

  // Reference rules expressed on the plain decimal count.
  task automatic model_step();
    if (reset_no_99 && model_cnt == 99) model_cnt = 0;
    else if (auto_repor && model_cnt < 5) model_cnt = 25;
    else if (inc) model_cnt = (model_cnt == 99) ? 99 : model_cnt + 1;
    else model_cnt = (model_cnt == 0) ? 0 : model_cnt - 1;
  endtask

  // Inputs are set after a negedge; sample 1ns after the rising edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check(tag, dout(), to_bcd(model_cnt));
    @(negedge clock);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    model_cnt = 0;
    #1;
    check(tag, dout(), to_bcd(0));
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic set_in(input logic i, input logic ar, input logic rn);
    inc = i;
    auto_repor = ar;
    reset_no_99 = rn;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b1, 1'b0, 1'b0);
    #3;
    check("reset_async", dout(), 8'h00);
    repeat (2) @(negedge clock);
    check("reset_held", dout(), 8'h00);
    reset = 1'b1;

    // Count up 22 edges, including the first carry at edge 10.
    for (int i = 0; i < 22; i++) tick("up22");
    check("up22_final", dout(), 8'h22);

    // Down from 12 through the borrow.
    async_reset("rst_a");
    for (int i = 0; i < 12; i++) tick("to12");
    set_in(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick("down_borrow");
    check("down_08", dout(), 8'h08);

    // Saturate at 99, then step down once.
    async_reset("rst_b");
    set_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 110; i++) tick("sat99");
    check("hold99", dout(), 8'h99);
    set_in(1'b0, 1'b0, 1'b0);
    tick("down98");
    check("is98", dout(), 8'h98);

    // Mid-run reset from 08, then one edge up gives 01.
    async_reset("rst_c");
    set_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick("to08");
    async_reset("rst_mid");
    tick("after_rst");
    check("is01", dout(), 8'h01);

    // Reload to 25 at 01, then down through 05, 04 into reload.
    set_in(1'b1, 1'b1, 1'b0);
    tick("reload25");
    check("is25", dout(), 8'h25);
    tick("is26");
    async_reset("rst_d");
    set_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick("to06");
    set_in(1'b0, 1'b1, 1'b0);
    tick("down05");
    tick("down04");
    check("is04", dout(), 8'h04);
    tick("reload_dn");
    check("is25_dn", dout(), 8'h25);

    // Clear-on-99, then down at 00 holds.
    async_reset("rst_e");
    set_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 97; i++) tick("to97");
    set_in(1'b1, 1'b0, 1'b1);
    tick("c98");
    tick("c99");
    tick("clr00");
    check("is00", dout(), 8'h00);
    set_in(1'b0, 1'b0, 1'b1);
    tick("hold00");
    check("hold00_v", dout(), 8'h00);

    // Randomized segments of biased direction with sparse control strobes.
    for (int seg = 0; seg < 40; seg++) begin
      logic dir;
      dir = ($urandom_range(0, 99) < 60);
      for (int i = 0; i < $urandom_range(5, 80); i++) begin
        set_in(($urandom_range(0, 9) < 8) ? dir : ~dir,
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
        tick("rand");
      end
      if ($urandom_range(0, 9) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
